// File: rtl/sram_d_arbiter_if.sv
// OBI-style request/response bundle shared by both upstream masters and the SRAM side.
// "master" drives the request channel; "slave" answers with gnt and the response channel.
interface sram_d_arbiter_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/sram_d_arbiter.sv
// Two-master arbiter in front of the SRAM data port with in-order response routing and range check.
// Define SRAM_D_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins ties); default is round-robin.
//
// Handshake: a request is accepted in the cycle where req && gnt are both high; the response
// (rvalid) for it appears exactly one cycle later, in acceptance order, on the issuing master.
module sram_d_arbiter #(
  parameter logic [31:0] SRAM_BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] SRAM_END_ADDR  = 32'h8000_C000,
  parameter int unsigned MAX_OUTST      = 2,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sram_d_arbiter_if.slave       m0,
  sram_d_arbiter_if.slave       m1,
  sram_d_arbiter_if.master      s,
  output logic                  illegal_o
);

  localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  typedef struct packed {
    logic id;
    logic err;
  } fifo_entry_t;

  fifo_entry_t      fifo_q [MAX_OUTST];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             fifo_full, fifo_empty;
  fifo_entry_t      head;

  logic             sel;
  logic             win_req;
  logic [31:0]      win_addr;
  logic             win_we;
  logic [3:0]       win_be;
  logic [31:0]      win_wdata;
  logic             win_illegal;
  logic             can_issue;
  logic             s_req;
  logic             win_gnt;
  logic             pop;
  logic             resp_valid;
  logic [31:0]      resp_rdata;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (count_q == CNT_W'(MAX_OUTST));
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_q[rd_ptr_q];

`ifdef SRAM_D_ARB_FIXED_PRIO_EN
  always_comb begin
    sel = ~m0.req;
  end
`else
  logic both_req;
  logic rr_q;

  assign both_req = m0.req & m1.req;

  always_comb begin
    sel = both_req ? rr_q : m1.req;
  end

  // Pointer only moves on a contested accept, so a lone requester never loses its turn.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= 1'b0;
    end else if (win_gnt && both_req) begin
      rr_q <= ~sel;
    end
  end
`endif

  always_comb begin
    win_req   = m0.req | m1.req;
    win_addr  = m0.addr;
    win_we    = m0.we;
    win_be    = m0.be;
    win_wdata = m0.wdata;
    if (sel) begin
      win_addr  = m1.addr;
      win_we    = m1.we;
      win_be    = m1.be;
      win_wdata = m1.wdata;
    end
    win_illegal = (win_addr < SRAM_BASE_ADDR) || (win_addr >= SRAM_END_ADDR);
    can_issue   = win_req & ~fifo_full & ~rst_i;
    s_req       = can_issue & ~win_illegal;
    // Out-of-range requests are absorbed locally, so they never wait on the SRAM grant.
    win_gnt     = can_issue & (win_illegal | s.gnt);
  end

  assign s.req     = s_req;
  assign s.addr    = s_req ? win_addr  : '0;
  assign s.we      = s_req & win_we;
  assign s.be      = s_req ? win_be    : '0;
  assign s.wdata   = s_req ? win_wdata : '0;
  assign m0.gnt    = win_gnt & ~sel;
  assign m1.gnt    = win_gnt & sel;
  assign illegal_o = can_issue & win_illegal;

  // Error entries complete on their own the cycle they reach the head.
  assign pop        = ~fifo_empty & (head.err | s.rvalid);
  assign resp_valid = pop & ~rst_i;
  assign resp_rdata = head.err ? ERR_RDATA : s.rdata;

  assign m0.rvalid = resp_valid & ~head.id;
  assign m0.rdata  = m0.rvalid ? resp_rdata : '0;
  assign m0.err    = m0.rvalid & head.err;
  assign m1.rvalid = resp_valid & head.id;
  assign m1.rdata  = m1.rvalid ? resp_rdata : '0;
  assign m1.err    = m1.rvalid & head.err;

  always_ff @(posedge clk_i) begin
    if (win_gnt) begin
      fifo_q[wr_ptr_q] <= '{id: sel, err: win_illegal};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (win_gnt) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)     rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_q + CNT_W'(win_gnt) - CNT_W'(pop);
    end
  end

  // A response from the SRAM must always have a legal transaction waiting for it.
  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
    s.rvalid |-> (!fifo_empty && !head.err));

endmodule

// File: tb/tb_sram_d_arbiter.sv
// Directed bench for sram_d_arbiter: default instance (depth 2) plus a depth-1 instance for stalls.
// Each stub SRAM answers one cycle after accept with rdata = {addr[15:0], 16'hA5A5}.
module tb_sram_d_arbiter;

  logic clk_i = 1'b0;
  logic rst_i;
  logic illegal, illegal1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk_i = ~clk_i;

  sram_d_arbiter_if m0_if ();
  sram_d_arbiter_if m1_if ();
  sram_d_arbiter_if s_if ();
  sram_d_arbiter_if n0_if ();
  sram_d_arbiter_if n1_if ();
  sram_d_arbiter_if ns_if ();

  sram_d_arbiter u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .m0(m0_if), .m1(m1_if), .s(s_if), .illegal_o(illegal)
  );

  sram_d_arbiter #(.MAX_OUTST(1)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .m0(n0_if), .m1(n1_if), .s(ns_if), .illegal_o(illegal1)
  );

  logic        sram_rv, sram1_rv;
  logic [31:0] sram_rd, sram1_rd;

  always @(posedge clk_i) begin
    if (rst_i) begin
      sram_rv  <= 1'b0;
      sram_rd  <= '0;
      sram1_rv <= 1'b0;
      sram1_rd <= '0;
    end else begin
      sram_rv  <= s_if.req & s_if.gnt;
      sram_rd  <= (s_if.req & s_if.gnt) ? {s_if.addr[15:0], 16'hA5A5} : '0;
      sram1_rv <= ns_if.req & ns_if.gnt;
      sram1_rd <= (ns_if.req & ns_if.gnt) ? {ns_if.addr[15:0], 16'hA5A5} : '0;
    end
  end

  assign s_if.rvalid  = sram_rv;
  assign s_if.rdata   = sram_rd;
  assign ns_if.rvalid = sram1_rv;
  assign ns_if.rdata  = sram1_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  task automatic drive_m0(input logic req, input logic [31:0] addr, input logic we);
    m0_if.req = req; m0_if.addr = addr; m0_if.we = we;
    m0_if.be = 4'hF; m0_if.wdata = addr ^ 32'hFFFF_0000;
  endtask

  task automatic drive_m1(input logic req, input logic [31:0] addr, input logic we);
    m1_if.req = req; m1_if.addr = addr; m1_if.we = we;
    m1_if.be = 4'hF; m1_if.wdata = addr ^ 32'hFFFF_0000;
  endtask

  task automatic drive_n(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1);
    n0_if.req = r0; n0_if.addr = a0; n0_if.we = 1'b0; n0_if.be = 4'hF; n0_if.wdata = '0;
    n1_if.req = r1; n1_if.addr = a1; n1_if.we = 1'b0; n1_if.be = 4'hF; n1_if.wdata = '0;
  endtask

  initial begin
    rst_i = 1'b1;
    s_if.gnt = 1'b1;  s_if.err = 1'b0;
    ns_if.gnt = 1'b1; ns_if.err = 1'b0;
    drive_m0(1'b1, 32'h8000_0010, 1'b0);
    drive_m1(1'b0, 32'h0, 1'b0);
    drive_n(1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;

    // Reset: outputs quiet even with a request pending
    mid();
    check("rst_m0_gnt", m0_if.gnt, 0);
    check("rst_s_req", s_if.req, 0);
    check("rst_illegal", illegal, 0);
    check("rst_m0_rvalid", m0_if.rvalid, 0);

    // Single legal read from m0
    step(); rst_i = 1'b0;
    mid();
    check("rd_s_req", s_if.req, 1);
    check("rd_m0_gnt", m0_if.gnt, 1);
    check("rd_m1_gnt", m1_if.gnt, 0);
    check("rd_s_addr", s_if.addr, 32'h8000_0010);
    check("rd_illegal", illegal, 0);
    step(); drive_m0(1'b0, 32'h0, 1'b0);
    mid();
    check("rd_m0_rvalid", m0_if.rvalid, 1);
    check("rd_m0_rdata", m0_if.rdata, 32'h0010_A5A5);
    check("rd_m0_err", m0_if.err, 0);
    check("rd_m1_rvalid", m1_if.rvalid, 0);
    check("rd_m1_rdata", m1_if.rdata, 0);

    // Both masters requesting continuously: alternate m0, m1, m0, m1
    step(); drive_m0(1'b1, 32'h8000_0100, 1'b0); drive_m1(1'b1, 32'h8000_0200, 1'b1);
    mid();
    check("rr0_m0_gnt", m0_if.gnt, 1);
    check("rr0_m1_gnt", m1_if.gnt, 0);
    check("rr0_s_addr", s_if.addr, 32'h8000_0100);
    step(); mid();
    check("rr1_m1_gnt", m1_if.gnt, 1);
    check("rr1_m0_gnt", m0_if.gnt, 0);
    check("rr1_s_addr", s_if.addr, 32'h8000_0200);
    check("rr1_s_we", s_if.we, 1);
    check("rr1_s_wdata", s_if.wdata, 32'h7FFF_0200);
    check("rr1_m0_rvalid", m0_if.rvalid, 1);
    check("rr1_m0_rdata", m0_if.rdata, 32'h0100_A5A5);
    step(); mid();
    check("rr2_m0_gnt", m0_if.gnt, 1);
    check("rr2_m1_rvalid", m1_if.rvalid, 1);
    check("rr2_m1_rdata", m1_if.rdata, 32'h0200_A5A5);
    check("rr2_m0_rvalid", m0_if.rvalid, 0);
    step(); mid();
    check("rr3_m1_gnt", m1_if.gnt, 1);
    check("rr3_m0_rvalid", m0_if.rvalid, 1);
    step(); drive_m0(1'b0, 32'h0, 1'b0); drive_m1(1'b0, 32'h0, 1'b0);
    mid();
    check("rr4_m1_rvalid", m1_if.rvalid, 1);
    check("rr4_m0_rvalid", m0_if.rvalid, 0);

    // m1 write to first address past the SRAM
    step(); drive_m1(1'b1, 32'h8000_C000, 1'b1);
    mid();
    check("ill_m1_gnt", m1_if.gnt, 1);
    check("ill_s_req", s_if.req, 0);
    check("ill_illegal", illegal, 1);
    step(); drive_m1(1'b0, 32'h0, 1'b0);
    mid();
    check("ill_m1_rvalid", m1_if.rvalid, 1);
    check("ill_m1_err", m1_if.err, 1);
    check("ill_m1_rdata", m1_if.rdata, 32'hDEAD_BEEF);
    check("ill_m0_rvalid", m0_if.rvalid, 0);
    check("ill_pulse_end", illegal, 0);

    // m0 legal (last word), illegal (below base), legal (base) back-to-back
    step(); drive_m0(1'b1, 32'h8000_BFFC, 1'b0);
    mid();
    check("b2b0_s_req", s_if.req, 1);
    check("b2b0_illegal", illegal, 0);
    step(); drive_m0(1'b1, 32'h7FFF_FFFC, 1'b0);
    mid();
    check("b2b1_s_req", s_if.req, 0);
    check("b2b1_m0_gnt", m0_if.gnt, 1);
    check("b2b1_illegal", illegal, 1);
    check("b2b1_rvalid", m0_if.rvalid, 1);
    check("b2b1_err", m0_if.err, 0);
    check("b2b1_rdata", m0_if.rdata, 32'hBFFC_A5A5);
    step(); drive_m0(1'b1, 32'h8000_0000, 1'b0);
    mid();
    check("b2b2_s_req", s_if.req, 1);
    check("b2b2_m0_gnt", m0_if.gnt, 1);
    check("b2b2_rvalid", m0_if.rvalid, 1);
    check("b2b2_err", m0_if.err, 1);
    check("b2b2_rdata", m0_if.rdata, 32'hDEAD_BEEF);
    step(); drive_m0(1'b0, 32'h0, 1'b0);
    mid();
    check("b2b3_rvalid", m0_if.rvalid, 1);
    check("b2b3_err", m0_if.err, 0);
    check("b2b3_rdata", m0_if.rdata, 32'h0000_A5A5);

    // Reset with one outstanding transaction and the rr pointer on m1
    step(); drive_m0(1'b1, 32'h8000_0020, 1'b0); drive_m1(1'b1, 32'h8000_0024, 1'b0);
    mid();
    check("rs_m0_gnt", m0_if.gnt, 1);
    check("rs_m1_gnt", m1_if.gnt, 0);
    step(); rst_i = 1'b1; drive_m0(1'b0, 32'h0, 1'b0); drive_m1(1'b0, 32'h0, 1'b0);
    mid();
    check("rs_m0_rvalid_in_rst", m0_if.rvalid, 0);
    check("rs_s_req_in_rst", s_if.req, 0);
    step(); rst_i = 1'b0;
    drive_m0(1'b1, 32'h8000_0030, 1'b0); drive_m1(1'b1, 32'h8000_0034, 1'b0);
    mid();
    check("rs_tie_m0_gnt", m0_if.gnt, 1);
    check("rs_tie_m1_gnt", m1_if.gnt, 0);
    check("rs_m0_rvalid", m0_if.rvalid, 0);
    check("rs_m1_rvalid", m1_if.rvalid, 0);
    step(); drive_m0(1'b0, 32'h0, 1'b0); drive_m1(1'b0, 32'h0, 1'b0);
    mid();
    check("rs_new_m0_rvalid", m0_if.rvalid, 1);
    check("rs_new_m0_rdata", m0_if.rdata, 32'h0030_A5A5);
    check("rs_new_m1_rvalid", m1_if.rvalid, 0);

    // Depth-1 instance: full FIFO and withheld SRAM grant
    step(); drive_n(1'b1, 32'h8000_0040, 1'b1, 32'h8000_0080);
    mid();
    check("st0_n0_gnt", n0_if.gnt, 1);
    check("st0_s_req", ns_if.req, 1);
    step(); ns_if.gnt = 1'b0;
    mid();
    check("st1_n0_gnt", n0_if.gnt, 0);
    check("st1_n1_gnt", n1_if.gnt, 0);
    check("st1_s_req", ns_if.req, 0);
    check("st1_n0_rvalid", n0_if.rvalid, 1);
    check("st1_n0_rdata", n0_if.rdata, 32'h0040_A5A5);
    step(); mid();
    check("st2_s_req", ns_if.req, 1);
    check("st2_s_addr", ns_if.addr, 32'h8000_0080);
    check("st2_n0_gnt", n0_if.gnt, 0);
    check("st2_n1_gnt", n1_if.gnt, 0);
    step(); ns_if.gnt = 1'b1;
    mid();
    check("st3_n1_gnt", n1_if.gnt, 1);
    check("st3_n0_gnt", n0_if.gnt, 0);
    step(); mid();
    check("st4_n0_gnt", n0_if.gnt, 0);
    check("st4_n1_gnt", n1_if.gnt, 0);
    check("st4_n1_rvalid", n1_if.rvalid, 1);
    check("st4_n1_rdata", n1_if.rdata, 32'h0080_A5A5);
    check("st4_illegal", illegal1, 0);
    step(); drive_n(1'b0, 32'h0, 1'b0, 32'h0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
